// File: rtl/lsu.sv
// Load/store unit: runs one request/acknowledge transaction against variable-latency
// data memory per accepted start, returning load data and a done/timeout status.
module lsu #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_f,
    input  logic        start,
    input  logic        we,
    input  logic [15:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] ld_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [1:0]  o_dbg_state
);

    // Memory handshake: mem_req is held high, with mem_we/mem_addr/mem_wdata stable,
    // until the rising edge at which mem_ack is sampled high (transfer completes,
    // mem_rdata valid in that same cycle) or the wait budget runs out.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [7:0] LP_TIMEOUT = 8'(TIMEOUT);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_cnt;
    logic [7:0]  w_cnt_inc;
    logic        w_timeout;
    logic        r_we;
    logic [15:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_err;
    logic [31:0] r_ld_data;

    // The edge that would complete the TIMEOUT-th request cycle is the timeout edge.
    assign w_cnt_inc = r_cnt + 8'd1;
    assign w_timeout = (w_cnt_inc == LP_TIMEOUT);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_REQ;
            S_REQ:   if (mem_ack || w_timeout) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            r_cnt     <= 8'd0;
            r_we      <= 1'b0;
            r_addr    <= 16'h0000;
            r_wdata   <= 32'h0;
            r_err     <= 1'b0;
            r_ld_data <= 32'h0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_we    <= we;
                        r_addr  <= addr;
                        r_wdata <= wdata;
                        r_err   <= 1'b0;
                        r_cnt   <= 8'd0;
                    end
                end
                S_REQ: begin
                    // An ack on the timeout edge still counts as success.
                    if (mem_ack) begin
                        if (!r_we) r_ld_data <= mem_rdata;
                    end else if (w_timeout) begin
                        r_err <= 1'b1;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy        = (r_state != S_IDLE);
    assign done        = (r_state == S_DONE);
    assign mem_req     = (r_state == S_REQ);
    assign err         = r_err;
    assign ld_data     = r_ld_data;
    assign mem_we      = r_we;
    assign mem_addr    = r_addr;
    assign mem_wdata   = r_wdata;
    assign o_dbg_state = r_state;

endmodule
